// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin owner of the frame-buffer write port with a priority bulk-clear sequencer
module fb_write_arbiter #(
  parameter int   ADDR_W      = 12,
  parameter int   DEPTH       = 4096,
  parameter logic CLEAR_VALUE = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_start,
  output logic              clear_done,
  output logic              busy,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              data1,
  output logic              ack1,
  output logic [ADDR_W-1:0] wraddress,
  output logic              data,
  output logic              wren
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wraddress_q, wraddress_d;
  logic              data_q, data_d, wren_q, wren_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              clear_done_q, clear_done_d, busy_q, busy_d;
  logic              last_grant_q, last_grant_d;
  logic              elig0, elig1, pick1;
  // A requester acked this cycle is still showing its old request, so it sits out one edge.
  always_comb begin
    elig0 = req0 & ~ack0_q;
    elig1 = req1 & ~ack1_q;
    pick1 = elig1 & (~elig0 | ~last_grant_q);
  end
  // Next-state and registered-output logic: clear beats arbitration, idle cycles hold address/data.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wraddress_d  = wraddress_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    clear_done_d = 1'b0;
    busy_d       = busy_q;
    last_grant_d = last_grant_q;
    if (state_q == CLEAR) begin
      if (cnt_q == LAST_ADDR) begin
        state_d      = IDLE;
        cnt_d        = '0;
        busy_d       = 1'b0;
        clear_done_d = 1'b1;
      end else begin
        cnt_d       = cnt_q + 1'b1;
        wraddress_d = cnt_q + 1'b1;
        data_d      = CLEAR_VALUE;
        wren_d      = 1'b1;
      end
    end else if (clear_start) begin
      state_d     = CLEAR;
      cnt_d       = '0;
      wraddress_d = '0;
      data_d      = CLEAR_VALUE;
      wren_d      = 1'b1;
      busy_d      = 1'b1;
    end else if (elig0 | elig1) begin
      wren_d       = 1'b1;
      wraddress_d  = pick1 ? addr1 : addr0;
      data_d       = pick1 ? data1 : data0;
      ack0_d       = ~pick1;
      ack1_d       = pick1;
      last_grant_d = pick1;
    end
  end
  // State and output registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wraddress_q  <= '0;
      data_q       <= 1'b0;
      wren_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wraddress_q  <= wraddress_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      clear_done_q <= clear_done_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign wraddress  = wraddress_q;
  assign data       = data_q;
  assign wren       = wren_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign clear_done = clear_done_q;
  assign busy       = busy_q;
endmodule
